// File: rtl/fetch_unit_pkg.sv
// Shared types for the instruction fetch stage: word type, fetch FSM states,
// queue entry layout and small PC helpers.
package fetch_unit_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [0:0] {
        RUN,
        HALTED
    } fetch_state_t;

    localparam word_t PC_INIT_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        word_t instr;
        word_t pc_plus_4;
    } fetch_entry_t;

    function automatic word_t pc_next(input word_t pc);
        return pc + 32'd4;
    endfunction

    function automatic word_t word_align(input word_t addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Icache and IF/ID-side signals of the fetch stage; fetch_cnt/flush_cnt are
// present only when FETCH_PERF_EN is defined.
interface fetch_unit_if;
    import fetch_unit_pkg::*;

    logic  iREN;
    word_t iaddr;
    logic  ihit;
    word_t iload;
    logic  redirect;
    word_t redirect_pc;
    logic  halt;
    logic  dec_ready;
    logic  instr_valid;
    word_t instr;
    word_t pc_plus_4;
`ifdef FETCH_PERF_EN
    word_t fetch_cnt;
    word_t flush_cnt;
`endif

    modport master (
        input  ihit, iload, redirect, redirect_pc, halt, dec_ready,
`ifdef FETCH_PERF_EN
        output fetch_cnt, flush_cnt,
`endif
        output iREN, iaddr, instr_valid, instr, pc_plus_4
    );

    modport slave (
        output ihit, iload, redirect, redirect_pc, halt, dec_ready,
`ifdef FETCH_PERF_EN
        input  fetch_cnt, flush_cnt,
`endif
        input  iREN, iaddr, instr_valid, instr, pc_plus_4
    );

endinterface

// File: rtl/fetch_unit_queue.sv
// Synchronous FIFO of fetched {instr, pc_plus_4} entries; flush dominates push and pop.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_unit_queue
    import fetch_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW = $clog2(DEPTH + 1)
) (
    input  logic          CLK,
    input  logic          nRST,
    input  logic          push,
    input  fetch_entry_t  push_data,
    input  logic          pop,
    input  logic          flush,
    output logic [CW-1:0] count,
    output fetch_entry_t  head
);

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && !flush && (count_q < CW'(DEPTH));
    assign do_pop  = pop && !flush && (count_q != '0);

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Stale slots stay in memory after a pop; hide them when empty.
    assign head  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, requests icache reads and queues returned
// instructions for decode. FETCH_PERF_EN adds fetch/flush counters.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter word_t       PC_INIT = PC_INIT_DEFAULT,
    parameter int unsigned QDEPTH  = 2
) (
    input logic         CLK,
    input logic         nRST,
    fetch_unit_if.master bus
);

    localparam int unsigned CW = $clog2(QDEPTH + 1);

    fetch_state_t  state_q;
    word_t         pc_q;
    logic [CW-1:0] count;
    fetch_entry_t  head;
    fetch_entry_t  push_data;
    logic          running;
    logic          flush;
    logic          accept;
    logic          push;
    logic          pop;
    logic          head_valid;

    assign running = (state_q == RUN);
    // Halt only matters while running; in HALTED both halt and redirect are ignored.
    assign flush   = running && (bus.redirect || bus.halt);

    assign bus.iREN  = nRST && running && (count < CW'(QDEPTH)) && !bus.redirect;
    assign bus.iaddr = pc_q;

    assign accept     = bus.iREN && bus.ihit;
    assign push       = accept && !flush;
    assign head_valid = nRST && running && (count != '0);
    assign pop        = head_valid && bus.dec_ready;

    assign push_data.instr     = bus.iload;
    assign push_data.pc_plus_4 = pc_next(pc_q);

    assign bus.instr_valid = head_valid;
    assign bus.instr       = head_valid ? head.instr : '0;
    assign bus.pc_plus_4   = head_valid ? head.pc_plus_4 : '0;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q <= RUN;
            pc_q    <= PC_INIT;
        end else if (running) begin
            if (bus.redirect) begin
                pc_q <= word_align(bus.redirect_pc);
            end else if (bus.halt) begin
                state_q <= HALTED;
            end else if (accept) begin
                pc_q <= pc_next(pc_q);
            end
        end
    end

    fetch_unit_queue #(
        .DEPTH (QDEPTH)
    ) u_queue (
        .CLK       (CLK),
        .nRST      (nRST),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (flush),
        .count     (count),
        .head      (head)
    );

`ifdef FETCH_PERF_EN
    word_t fetch_cnt_q;
    word_t flush_cnt_q;

    // A flush discards every queued entry plus any same-cycle hit from the icache.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            fetch_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (push) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if (flush) begin
                flush_cnt_q <= flush_cnt_q + 32'(count) + 32'(bus.ihit);
            end
        end
    end

    assign bus.fetch_cnt = fetch_cnt_q;
    assign bus.flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed stimulus pushes expected queue
// entries into a scoreboard that a negedge monitor drains on every pop.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic CLK = 1'b0;
    logic nRST;
    always #5 CLK = ~CLK;

    fetch_unit_if bus ();
    fetch_unit_if bus2 ();

    fetch_unit #(.PC_INIT(32'h0000_0000), .QDEPTH(2)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus.master)
    );

    fetch_unit #(.PC_INIT(32'hFFFF_FFF8), .QDEPTH(2)) dut_wrap (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus2.master)
    );

    int           n_checks = 0;
    int           n_fail   = 0;
    fetch_entry_t exp_q[$];
    fetch_entry_t mon_e;

    task automatic check(input string name, input word_t act, input word_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input word_t i, input word_t p);
        fetch_entry_t e;
        e.instr     = i;
        e.pc_plus_4 = p;
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic h, input word_t ld, input logic dr);
        bus.ihit      = h;
        bus.iload     = ld;
        bus.dec_ready = dr;
        bus.redirect  = 1'b0;
        bus.halt      = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic at_sample();
        @(negedge CLK);
    endtask

    // Scoreboard monitor: every real pop must match the oldest expected entry.
    always @(negedge CLK) begin
        if (nRST && bus.instr_valid && bus.dec_ready && !bus.redirect && !bus.halt) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected: got %h, expected no entry", bus.instr);
            end else begin
                mon_e = exp_q.pop_front();
                check("sb_instr", bus.instr, mon_e.instr);
                check("sb_pc_plus_4", bus.pc_plus_4, mon_e.pc_plus_4);
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    word_t wrap_addr  [4] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
    word_t wrap_pc4   [4] = '{32'h0000_0000, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};

    initial begin
        nRST = 1'b0;
        drive(1'b0, '0, 1'b0);
        bus.redirect_pc  = '0;
        bus2.ihit        = 1'b1;
        bus2.iload       = 32'hCAFE_0000;
        bus2.dec_ready   = 1'b1;
        bus2.redirect    = 1'b0;
        bus2.redirect_pc = '0;
        bus2.halt        = 1'b0;
        repeat (2) @(posedge CLK);
        #1;

        at_sample();
        check("rst_iren", 32'(bus.iREN), 32'd0);
        check("rst_valid", 32'(bus.instr_valid), 32'd0);
        check("rst_instr", bus.instr, 32'd0);
        check("rst_pc4", bus.pc_plus_4, 32'd0);
        check("rst_iaddr", bus.iaddr, 32'd0);
        check("rst_wrap_iaddr", bus2.iaddr, 32'hFFFF_FFF8);
        next_cycle();
        nRST = 1'b1;

        // Steady streaming with hits and decode ready every cycle.
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 32'h1000_0000 + 32'(k), 1'b1);
            push_exp(32'h1000_0000 + 32'(k), 32'(4 * (k + 1)));
            at_sample();
            check("steady_iaddr", bus.iaddr, 32'(4 * k));
            check("steady_valid", 32'(bus.instr_valid), 32'(k != 0));
            check("wrap_iaddr", bus2.iaddr, wrap_addr[k]);
            check("wrap_pc4", bus2.pc_plus_4, wrap_pc4[k]);
            next_cycle();
        end
        drive(1'b0, '0, 1'b1);
        at_sample();
        check("steady_end_iaddr", bus.iaddr, 32'h10);
        next_cycle();

        // Backpressure: fill the queue, iREN drops, address holds, then drain.
        drive(1'b1, 32'h2000_0000, 1'b0);
        push_exp(32'h2000_0000, 32'h14);
        at_sample();
        check("bp_iaddr0", bus.iaddr, 32'h10);
        next_cycle();
        drive(1'b1, 32'h2000_0001, 1'b0);
        push_exp(32'h2000_0001, 32'h18);
        at_sample();
        check("bp_iaddr1", bus.iaddr, 32'h14);
        next_cycle();
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 32'hDEAD_BEEF, 1'b0);
            at_sample();
            check("bp_full_iren", 32'(bus.iREN), 32'd0);
            check("bp_full_iaddr", bus.iaddr, 32'h18);
            check("bp_full_valid", 32'(bus.instr_valid), 32'd1);
            next_cycle();
        end
        drive(1'b0, '0, 1'b1);
        at_sample();
        check("bp_pop_iren", 32'(bus.iREN), 32'd0);
        next_cycle();
        drive(1'b0, '0, 1'b1);
        at_sample();
        check("bp_resume_iren", 32'(bus.iREN), 32'd1);
        check("bp_resume_iaddr", bus.iaddr, 32'h18);
        next_cycle();
        drive(1'b0, '0, 1'b0);
        at_sample();
        check("bp_empty_valid", 32'(bus.instr_valid), 32'd0);
        next_cycle();

        // Redirect with a full queue and a same-cycle hit.
        drive(1'b1, 32'h3000_0000, 1'b0);
        push_exp(32'h3000_0000, 32'h1C);
        next_cycle();
        drive(1'b1, 32'h3000_0001, 1'b0);
        push_exp(32'h3000_0001, 32'h20);
        next_cycle();
        drive(1'b1, 32'hBAD0_0001, 1'b0);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0000_0103;
        exp_q.delete();
        at_sample();
        check("redir_iren", 32'(bus.iREN), 32'd0);
        next_cycle();
        drive(1'b0, '0, 1'b0);
        at_sample();
        check("redir_valid", 32'(bus.instr_valid), 32'd0);
        check("redir_iaddr", bus.iaddr, 32'h100);
        check("redir_iren_back", 32'(bus.iREN), 32'd1);
`ifdef FETCH_PERF_EN
        check("redir_flush_cnt", bus.flush_cnt, 32'd3);
        check("redir_fetch_cnt", bus.fetch_cnt, 32'd8);
`endif
        next_cycle();
        drive(1'b1, 32'h4000_0000, 1'b0);
        push_exp(32'h4000_0000, 32'h104);
        next_cycle();
        drive(1'b0, '0, 1'b1);
        at_sample();
        check("redir_target_valid", 32'(bus.instr_valid), 32'd1);
        next_cycle();

        // Halt together with redirect: redirect wins.
        drive(1'b0, '0, 1'b0);
        bus.halt        = 1'b1;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0000_0040;
        next_cycle();
        drive(1'b1, 32'h5000_0000, 1'b0);
        push_exp(32'h5000_0000, 32'h44);
        at_sample();
        check("halt_redir_iren", 32'(bus.iREN), 32'd1);
        check("halt_redir_iaddr", bus.iaddr, 32'h40);
        next_cycle();

        // Halt alone with one entry queued and a same-cycle hit.
        drive(1'b1, 32'hBAD0_0002, 1'b0);
        bus.halt = 1'b1;
        exp_q.delete();
        next_cycle();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'hBAD0_0003, 1'b1);
            bus.redirect    = 1'b1;
            bus.redirect_pc = 32'h0000_0200;
            at_sample();
            check("halted_iren", 32'(bus.iREN), 32'd0);
            check("halted_valid", 32'(bus.instr_valid), 32'd0);
            check("halted_iaddr", bus.iaddr, 32'h44);
            next_cycle();
        end
        drive(1'b1, 32'hBAD0_0004, 1'b1);
        at_sample();
        check("halted_stay_iren", 32'(bus.iREN), 32'd0);
`ifdef FETCH_PERF_EN
        check("halt_flush_cnt", bus.flush_cnt, 32'd5);
        check("halt_fetch_cnt", bus.fetch_cnt, 32'd10);
`endif
        next_cycle();

        // Reset out of HALTED, queue two entries, then reset mid-stream.
        nRST = 1'b0;
        drive(1'b0, '0, 1'b0);
        next_cycle();
        nRST = 1'b1;
        drive(1'b1, 32'h6000_0000, 1'b0);
        at_sample();
        check("rerun_iaddr0", bus.iaddr, 32'h0);
        next_cycle();
        drive(1'b1, 32'h6000_0001, 1'b0);
        at_sample();
        check("rerun_iaddr1", bus.iaddr, 32'h4);
        next_cycle();
        nRST = 1'b0;
        drive(1'b1, 32'h6000_0002, 1'b1);
        at_sample();
        check("midrst_iren", 32'(bus.iREN), 32'd0);
        check("midrst_valid", 32'(bus.instr_valid), 32'd0);
        check("midrst_instr", bus.instr, 32'd0);
        check("midrst_pc4", bus.pc_plus_4, 32'd0);
        next_cycle();
        nRST = 1'b1;
        drive(1'b0, '0, 1'b0);
        at_sample();
        check("postrst_valid", 32'(bus.instr_valid), 32'd0);
        check("postrst_iaddr", bus.iaddr, 32'h0);
        check("postrst_iren", 32'(bus.iREN), 32'd1);
        check("postrst_pc4", bus.pc_plus_4, 32'd0);
`ifdef FETCH_PERF_EN
        check("postrst_fetch_cnt", bus.fetch_cnt, 32'd0);
        check("postrst_flush_cnt", bus.flush_cnt, 32'd0);
`endif
        next_cycle();
        drive(1'b1, 32'h7000_0000, 1'b0);
        push_exp(32'h7000_0000, 32'h4);
        next_cycle();
        drive(1'b0, '0, 1'b1);
        next_cycle();
        drive(1'b0, '0, 1'b0);
        at_sample();
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
